// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module  : apb_master
// Brief   : Single-command valid/ready to APB bridge with wait-state timeout.
// Revision: 1.0 - initial release
// ============================================================================
module apb_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        P_clk,
    input  logic        P_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] P_addr,
    output logic        P_selx,
    output logic        P_enable,
    output logic        P_write,
    output logic [31:0] P_wdata,
    input  logic        P_ready,
    input  logic        P_slverr,
    input  logic [31:0] P_rdata
);

    localparam int c_CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;
    localparam logic [1:0] c_ST_RESP   = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_err;
    logic [31:0]        r_addr;
    logic               r_selx;
    logic               r_enable;
    logic               r_write;
    logic [31:0]        r_wdata;
    logic               w_aligned;

    assign w_aligned = (cmd_addr[1:0] == 2'b00);

    // Only combinational output; masked by reset so nothing is taken while P_rst is high.
    assign cmd_ready = (r_state == c_ST_IDLE) && !P_rst;

    always_ff @(posedge P_clk) begin
        if (P_rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_addr      <= 32'd0;
            r_selx      <= 1'b0;
            r_enable    <= 1'b0;
            r_write     <= 1'b0;
            r_wdata     <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd_valid) begin
                        if (w_aligned) begin
                            r_addr  <= cmd_addr;
                            r_write <= cmd_write;
                            r_wdata <= cmd_wdata;
                            r_selx  <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= c_ST_SETUP;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'd0;
                            r_state     <= c_ST_RESP;
                        end
                    end
                end
                c_ST_SETUP: begin
                    r_enable <= 1'b1;
                    r_state  <= c_ST_ACCESS;
                end
                c_ST_ACCESS: begin
                    if (P_ready) begin
                        r_selx      <= 1'b0;
                        r_enable    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= P_slverr;
                        r_rsp_rdata <= (!r_write && !P_slverr) ? P_rdata : 32'd0;
                        r_state     <= c_ST_RESP;
                    end else if ((TIMEOUT != 0) && (r_cnt == c_CNT_MAX)) begin
                        // Counter already covers every earlier stalled ACCESS cycle.
                        r_selx      <= 1'b0;
                        r_enable    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= 32'd0;
                        r_state     <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign P_addr    = r_addr;
    assign P_selx    = r_selx;
    assign P_enable  = r_enable;
    assign P_write   = r_write;
    assign P_wdata   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_apb_master
// Brief   : Self-checking bench for apb_master with a reactive APB slave.
// Revision: 1.0 - initial release
// ============================================================================
module tb_apb_master;

    localparam int TIMEOUT = 16;

    logic        P_clk = 1'b0;
    logic        P_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] P_addr;
    logic        P_selx;
    logic        P_enable;
    logic        P_write;
    logic [31:0] P_wdata;
    logic        P_ready;
    logic        P_slverr;
    logic [31:0] P_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [16];
    logic [31:0] slave_mem [16];
    logic [31:0] last_addr;

    apb_master #(.TIMEOUT(TIMEOUT)) dut (
        .P_clk     (P_clk),
        .P_rst     (P_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .P_addr    (P_addr),
        .P_selx    (P_selx),
        .P_enable  (P_enable),
        .P_write   (P_write),
        .P_wdata   (P_wdata),
        .P_ready   (P_ready),
        .P_slverr  (P_slverr),
        .P_rdata   (P_rdata)
    );

    always #5 P_clk = ~P_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One command end to end; expectations come from the transaction rules, not the FSM.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic serr, input int hold, input logic keep_valid);
        logic        aligned;
        int          exp_lat;
        int          exp_sel;
        int          exp_acc;
        logic        exp_err;
        logic [31:0] exp_data;
        int          e;
        int          sel;
        int          acc;
        logic        done;
        logic        stable_ok;

        aligned = (addr[1:0] == 2'b00);
        if (!aligned) begin
            exp_lat = 0; exp_sel = 0; exp_acc = 0; exp_err = 1'b1; exp_data = 32'd0;
        end else if (waits >= TIMEOUT) begin
            exp_lat = 1 + TIMEOUT; exp_sel = TIMEOUT + 1; exp_acc = TIMEOUT;
            exp_err = 1'b1; exp_data = 32'd0;
        end else begin
            exp_lat = 2 + waits; exp_sel = waits + 2; exp_acc = waits + 1; exp_err = serr;
            exp_data = (wr || serr) ? 32'd0 : model_mem[addr[5:2]];
            if (wr && !serr) model_mem[addr[5:2]] = wdata;
        end

        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; P_ready = 1'b0;
        @(negedge P_clk);
        if (!keep_valid) cmd_valid = 1'b0;

        e = 0; sel = 0; acc = 0; done = 1'b0; stable_ok = 1'b1;
        while (!done && e <= exp_lat + 4) begin
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                if (P_selx) begin
                    sel++;
                    if (P_addr !== addr || P_write !== wr || (wr && P_wdata !== wdata)) stable_ok = 1'b0;
                end
                if (P_enable) acc++;
                if (P_enable && !P_selx) stable_ok = 1'b0;
                if (cmd_ready !== 1'b0) stable_ok = 1'b0;
                P_ready  = P_enable && (acc == waits + 1);
                P_slverr = P_ready && serr;
                P_rdata  = (P_ready && !serr) ? slave_mem[P_addr[5:2]] : $urandom();
                if (P_ready && P_write && !serr) slave_mem[P_addr[5:2]] = P_wdata;
                @(negedge P_clk);
                e++;
            end
        end
        P_ready = 1'b0; P_slverr = 1'b0; cmd_valid = 1'b0;

        check("rsp_seen", {31'd0, done}, 32'd1);
        check("rsp_latency", e, exp_lat);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        check("rsp_rdata", rsp_rdata, exp_data);
        check("selx_cycles", sel, exp_sel);
        check("enable_cycles", acc, exp_acc);
        check("apb_idle_at_rsp", {30'd0, P_selx, P_enable}, 32'd0);
        check("apb_stable", {31'd0, stable_ok}, 32'd1);
        if (!aligned) check("addr_held", P_addr, last_addr);
        else last_addr = addr;

        for (int h = 0; h < hold; h++) begin
            @(negedge P_clk);
            check("rsp_hold_ctl", {29'd0, rsp_valid, rsp_err, cmd_ready}, {29'd0, 1'b1, exp_err, 1'b0});
            check("rsp_hold_data", rsp_rdata, exp_data);
        end
        rsp_ready = 1'b1;
        @(negedge P_clk);
        rsp_ready = 1'b0;
        check("rsp_consumed", {30'd0, rsp_valid, cmd_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        int          w;

        P_rst = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4; cmd_wdata = 32'h1;
        rsp_ready = 1'b0; P_ready = 1'b0; P_slverr = 1'b0; P_rdata = 32'd0;
        for (int i = 0; i < 16; i++) begin
            a = $urandom();
            model_mem[i] = a;
            slave_mem[i] = a;
        end
        last_addr = 32'd0;

        repeat (3) @(negedge P_clk);
        check("reset_ctl", {26'd0, cmd_ready, rsp_valid, rsp_err, P_selx, P_enable, P_write}, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        check("reset_addr", P_addr, 32'd0);
        check("reset_wdata", P_wdata, 32'd0);
        cmd_valid = 1'b0;
        P_rst = 1'b0;
        @(negedge P_clk);

        run_txn(1'b1, 32'h4, 32'h7, 0, 1'b0, 0, 1'b0);
        run_txn(1'b0, 32'h4, 32'h0, 0, 1'b0, 0, 1'b0);
        run_txn(1'b0, 32'h4, 32'h0, 3, 1'b0, 0, 1'b1);
        run_txn(1'b0, 32'h8, 32'h0, TIMEOUT + 4, 1'b0, 0, 1'b0);
        run_txn(1'b1, 32'h6, 32'h55, 0, 1'b0, 0, 1'b0);
        run_txn(1'b0, 32'h4, 32'h0, 1, 1'b1, 0, 1'b0);
        run_txn(1'b0, 32'h4, 32'h0, 0, 1'b0, 4, 1'b0);

        // Reset mid-transfer: no response may follow, and the bridge must recover.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hAA; P_ready = 1'b0;
        @(negedge P_clk);
        cmd_valid = 1'b0;
        @(negedge P_clk);
        check("abort_in_access", {30'd0, P_selx, P_enable}, 32'd3);
        P_rst = 1'b1;
        @(negedge P_clk);
        check("abort_apb", {28'd0, P_selx, P_enable, rsp_valid, cmd_ready}, 32'd0);
        P_rst = 1'b0;
        last_addr = 32'd0;
        repeat (3) begin
            @(negedge P_clk);
            check("abort_no_rsp", {30'd0, rsp_valid, cmd_ready}, 32'd1);
        end
        run_txn(1'b1, 32'h10, 32'h1234_5678, 0, 1'b0, 0, 1'b0);
        run_txn(1'b0, 32'h10, 32'h0, 2, 1'b0, 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            a = $urandom_range(0, 15) << 2;
            if ($urandom_range(0, 7) == 0) a = a | $urandom_range(1, 3);
            w = ($urandom_range(0, 9) == 0) ? TIMEOUT + 2 : int'($urandom_range(0, 4));
            run_txn(1'($urandom_range(0, 1)), a, $urandom(), w,
                    1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
